if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_in  input  1  reset, synchronous, active-high.
REQ-003 rdy_in  input  1  global ready; low freezes all internal state and outputs.
REQ-004 stall_in  input  1  downstream (IF_ID/ID) cannot accept; hold presented instruction.
REQ-005 jump_en  input  1  redirect request from EX/branch logic, single-cycle pulse.
REQ-006 jump_target  input  32  redirect address; bits [1:0] forced to 0 on capture.
REQ-007 mem_din  input  8  memory read byte, valid one cycle after its address.
REQ-008 mem_a  output  32  memory byte address.
REQ-009 mem_rd_en  output  1  memory read strobe.
REQ-010 output_pc  output  32  PC of presented instruction, to IF_ID input_pc.
REQ-011 output_instru  output  32  assembled instruction, to IF_ID input_instru.
REQ-012 output_valid  output  1  output_pc/output_instru hold a valid fetched instruction.

Function
REQ-013 States SHALL be IDLE, FETCH (byte counter cnt 0..4), DONE.
REQ-014 IDLE SHALL go to FETCH cnt=0 on next edge when rdy_in=1.
REQ-015 In FETCH cnt=c, c in 0..3: mem_a SHALL equal pc+c and mem_rd_en SHALL be 1.
REQ-016 In FETCH cnt=4 and in DONE and IDLE: mem_rd_en SHALL be 0, mem_a SHALL be 0.
REQ-017 In FETCH cnt=c, c in 1..4: mem_din SHALL be captured as byte c-1, little-endian (byte0 -> instr[7:0], byte3 -> instr[31:24]).
REQ-018 On the edge leaving cnt=4: output_instru SHALL load the assembled word, output_pc SHALL load pc, pc SHALL advance by 4 (32-bit wrap from 0xFFFFFFFC to 0), state SHALL go to DONE.
REQ-019 In DONE output_valid SHALL be 1; elsewhere 0.
REQ-020 In DONE with stall_in=0: next state SHALL be FETCH cnt=0; with stall_in=1: remain in DONE, outputs unchanged.
REQ-021 Latency: FETCH cnt=0 to output_valid high SHALL be 5 cycles; throughput one instruction per 6 cycles unstalled.
REQ-022 jump_en=1 in any state SHALL, at that edge, set pc to {jump_target[31:2],2'b00}, discard captured bytes, set output_valid to 0 next cycle, and enter FETCH cnt=0.
REQ-023 jump_en SHALL take priority over stall_in and over completion at cnt=4 (completed word discarded, pc not advanced by 4).
REQ-024 rdy_in=0 SHALL hold state, counter, pc and all outputs; memory byte arriving during freeze is not captured (memory assumed frozen too). jump_en while rdy_in=0 SHALL be ignored.
REQ-025 output_pc/output_instru SHALL change only on the edge leaving cnt=4, on jump (instru/pc retained, valid cleared), or reset.

Reset
REQ-026 rst_in=1 at an edge SHALL set state IDLE, cnt 0, pc 0x00000000, byte buffer 0, output_pc 0, output_instru 0, output_valid 0, mem_a 0, mem_rd_en 0; overrides rdy_in and jump_en.
REQ-027 Reset mid-FETCH SHALL abort the fetch with no output_valid pulse.

Structure
REQ-028 State encodings, reset PC (0x00000000) and ZeroWorld/Rstdisable-style constants SHALL live in the shared define file; bus widths via InstAddrBus/InstDataBus macros.
REQ-029 No sub-module; single always block for state, combinational block for mem_a/mem_rd_en.

Verification
REQ-030 Reset release, memory[0..3]=13 05 50 00, stall_in=0 -> output_valid first high in 7th cycle after reset deasserted, output_pc=0, output_instru=0x00500513; next fetch mem_a=4.
REQ-031 Stall: stall_in=1 during DONE for 3 cycles -> output_valid high 3+1 cycles, outputs unchanged, mem_rd_en 0; fetch of pc 4 starts cycle after stall drops.
REQ-032 Jump at cnt=2 with jump_target=0x00001003 -> next mem_a=0x00001000, no valid for aborted fetch, next output_pc=0x00001000.
REQ-033 Jump and stall_in both high in DONE -> output_valid 0 next cycle, fetch starts at target.
REQ-034 rdy_in low 2 cycles at cnt=1 -> mem_a/pc frozen, resulting instruction identical to unfrozen run, latency +2.
REQ-035 pc=0xFFFFFFFC fetch completes -> output_pc=0xFFFFFFFC, next mem_a=0x00000000.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared constants for the instruction fetch unit: bus widths, state
// encodings, reset values and the jump-target alignment helper.
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_DATA_W = 32;
    localparam int BYTE_W      = 8;
    localparam int CNT_W       = 3;
    // Bytes 0..2 are buffered; byte 3 goes straight into the output word.
    localparam int BUF_W       = 24;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ZERO = 3'd0;
    localparam logic [CNT_W-1:0] CNT_LAST = 3'd4;

    localparam logic [INST_ADDR_W-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [INST_DATA_W-1:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [INST_ADDR_W-1:0] PC_STEP   = 32'd4;

    // Instructions are word aligned: low two address bits are dropped.
    function automatic logic [INST_ADDR_W-1:0] align_word(input logic [INST_ADDR_W-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: reads a 32-bit instruction one byte per cycle from a
// byte-wide memory (data one cycle after address), assembles it little-endian
// and presents it with its PC to the IF/ID stage, honouring stall, jump
// redirect and a global ready/freeze.
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   stall_in,
    input  logic                   jump_en,
    input  logic [INST_ADDR_W-1:0] jump_target,
    input  logic [BYTE_W-1:0]      mem_din,
    output logic [INST_ADDR_W-1:0] mem_a,
    output logic                   mem_rd_en,
    output logic [INST_ADDR_W-1:0] output_pc,
    output logic [INST_DATA_W-1:0] output_instru,
    output logic                   output_valid
);

    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [INST_ADDR_W-1:0] r_pc;
    logic [BUF_W-1:0]       r_buf;
    logic [INST_ADDR_W-1:0] r_out_pc;
    logic [INST_DATA_W-1:0] r_out_instru;
    logic                   r_valid;

    logic [INST_ADDR_W-1:0] w_mem_a;
    logic                   w_mem_rd_en;

    // Fetch sequencer: state, byte counter, PC, byte buffer and presented outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= ST_IDLE;
            r_cnt        <= CNT_ZERO;
            r_pc         <= RESET_PC;
            r_buf        <= '0;
            r_out_pc     <= RESET_PC;
            r_out_instru <= ZERO_WORD;
            r_valid      <= 1'b0;
        end else if (rdy_in) begin
            if (jump_en) begin
                // Redirect wins over stall and over a word completing this edge;
                // the presented pc/instru are kept, only valid is dropped.
                r_pc    <= align_word(jump_target);
                r_buf   <= '0;
                r_state <= ST_FETCH;
                r_cnt   <= CNT_ZERO;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_FETCH;
                        r_cnt   <= CNT_ZERO;
                        r_valid <= 1'b0;
                    end
                    ST_FETCH: begin
                        if (r_cnt == CNT_LAST) begin
                            // Last byte arrives now; it lands directly in the top byte.
                            r_out_instru <= {mem_din, r_buf};
                            r_out_pc     <= r_pc;
                            r_pc         <= r_pc + PC_STEP;
                            r_buf        <= '0;
                            r_state      <= ST_DONE;
                            r_cnt        <= CNT_ZERO;
                            r_valid      <= 1'b1;
                        end else begin
                            // mem_din carries the byte addressed in the previous cycle.
                            case (r_cnt)
                                3'd1:    r_buf[7:0]   <= mem_din;
                                3'd2:    r_buf[15:8]  <= mem_din;
                                3'd3:    r_buf[23:16] <= mem_din;
                                default: ;
                            endcase
                            r_cnt   <= r_cnt + 3'd1;
                            r_valid <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        if (!stall_in) begin
                            r_state <= ST_FETCH;
                            r_cnt   <= CNT_ZERO;
                            r_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Memory address/strobe: active only while bytes 0..3 are being requested.
    always_comb begin
        w_mem_a     = ZERO_WORD;
        w_mem_rd_en = 1'b0;
        if ((r_state == ST_FETCH) && (r_cnt != CNT_LAST)) begin
            w_mem_a     = r_pc + {29'd0, r_cnt};
            w_mem_rd_en = 1'b1;
        end
    end

    assign mem_a         = w_mem_a;
    assign mem_rd_en     = w_mem_rd_en;
    assign output_pc     = r_out_pc;
    assign output_instru = r_out_instru;
    assign output_valid  = r_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed scenarios for reset, basic fetch, stall,
// jump, freeze and PC wrap, plus a randomized run checked against a
// transaction-level model of the instruction stream.
module tb_if_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        stall_in;
    logic        jump_en;
    logic [31:0] jump_target;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic        mem_rd_en;
    logic [31:0] output_pc;
    logic [31:0] output_instru;
    logic        output_valid;

    logic [7:0]  mem [0:65535];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    if_fetch dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .stall_in      (stall_in),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .mem_din       (mem_din),
        .mem_a         (mem_a),
        .mem_rd_en     (mem_rd_en),
        .output_pc     (output_pc),
        .output_instru (output_instru),
        .output_valid  (output_valid)
    );

    // Byte memory, one cycle read latency, frozen together with the fetch unit.
    always @(posedge clk_in) begin
        if (rdy_in && mem_rd_en) mem_din <= mem[mem_a[15:0]];
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [15:0] i0, i1, i2, i3;
        i0 = a[15:0];
        i1 = i0 + 16'd1;
        i2 = i0 + 16'd2;
        i3 = i0 + 16'd3;
        return {mem[i3], mem[i2], mem[i1], mem[i0]};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; rdy_in = 1'b1; stall_in = 1'b0; jump_en = 1'b0;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int ticks);
        ticks = 0;
        while (!output_valid && ticks < limit) begin
            tick();
            ticks++;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b0; stall_in = 1'b1; jump_en = 1'b1; jump_target = 32'h0000_1234;
        tick();
        rdy_in = 1'b1;
        tick();
        jump_en = 1'b0; stall_in = 1'b0;
        n_cmp++; if (output_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", output_valid); end
        n_cmp++; if (output_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %08h expected 00000000", output_pc); end
        n_cmp++; if (output_instru !== 32'h0) begin n_err++; $display("FAIL reset_instru: got %08h expected 00000000", output_instru); end
        n_cmp++; if (mem_a !== 32'h0) begin n_err++; $display("FAIL reset_mem_a: got %08h expected 00000000", mem_a); end
        n_cmp++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %0b expected 0", mem_rd_en); end
    endtask

    task automatic test_basic();
        logic [33:0] got, exp;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp = {(k == 6), (k <= 4), (k <= 4) ? 32'(k - 1) : 32'h0};
            got = {output_valid, mem_rd_en, mem_a};
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL basic_seq cycle %0d: got v/rd/a %09h expected %09h", k + 1, got, exp); end
        end
        n_cmp++; if (output_pc !== 32'h0) begin n_err++; $display("FAIL basic_pc: got %08h expected 00000000", output_pc); end
        n_cmp++; if (output_instru !== 32'h0050_0513) begin n_err++; $display("FAIL basic_instru: got %08h expected 00500513", output_instru); end
        tick();
        n_cmp++; if ({output_valid, mem_rd_en, mem_a} !== {1'b0, 1'b1, 32'h4}) begin n_err++; $display("FAIL basic_next: got v=%0b rd=%0b a=%08h expected v=0 rd=1 a=00000004", output_valid, mem_rd_en, mem_a); end
    endtask

    task automatic test_stall();
        int t;
        do_reset();
        stall_in = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        n_cmp++; if (output_valid !== 1'b1) begin n_err++; $display("FAIL stall_first_valid: got %0b expected 1", output_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if ({output_valid, mem_rd_en, output_pc, output_instru} !== {1'b1, 1'b0, 32'h0, 32'h0050_0513}) begin
                n_err++;
                $display("FAIL stall_hold %0d: got v=%0b rd=%0b pc=%08h ins=%08h expected v=1 rd=0 pc=00000000 ins=00500513", k, output_valid, mem_rd_en, output_pc, output_instru);
            end
        end
        stall_in = 1'b0;
        tick();
        n_cmp++; if ({output_valid, mem_rd_en, mem_a} !== {1'b0, 1'b1, 32'h4}) begin n_err++; $display("FAIL stall_release: got v=%0b rd=%0b a=%08h expected v=0 rd=1 a=00000004", output_valid, mem_rd_en, mem_a); end
        wait_valid(20, t);
        n_cmp++; if (t !== 5) begin n_err++; $display("FAIL stall_next_latency: got %0d expected 5", t); end
        n_cmp++; if (output_pc !== 32'h4 || output_instru !== ref_word(32'h4)) begin n_err++; $display("FAIL stall_next_word: got pc=%08h ins=%08h expected pc=00000004 ins=%08h", output_pc, output_instru, ref_word(32'h4)); end
    endtask

    task automatic test_jump();
        int t;
        do_reset();
        tick(); tick(); tick();
        jump_en = 1'b1; jump_target = 32'h0000_1003;
        tick();
        jump_en = 1'b0;
        n_cmp++; if ({output_valid, mem_rd_en, mem_a} !== {1'b0, 1'b1, 32'h1000}) begin n_err++; $display("FAIL jump_addr: got v=%0b rd=%0b a=%08h expected v=0 rd=1 a=00001000", output_valid, mem_rd_en, mem_a); end
        wait_valid(20, t);
        n_cmp++; if (t !== 5) begin n_err++; $display("FAIL jump_latency: got %0d expected 5", t); end
        n_cmp++; if (output_pc !== 32'h1000 || output_instru !== ref_word(32'h1000)) begin n_err++; $display("FAIL jump_word: got pc=%08h ins=%08h expected pc=00001000 ins=%08h", output_pc, output_instru, ref_word(32'h1000)); end
    endtask

    task automatic test_jump_stall();
        do_reset();
        stall_in = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        jump_en = 1'b1; jump_target = 32'h0000_2A57;
        tick();
        jump_en = 1'b0; stall_in = 1'b0;
        n_cmp++; if ({output_valid, mem_rd_en, mem_a} !== {1'b0, 1'b1, 32'h2A54}) begin n_err++; $display("FAIL jstall_addr: got v=%0b rd=%0b a=%08h expected v=0 rd=1 a=00002a54", output_valid, mem_rd_en, mem_a); end
        n_cmp++; if (output_pc !== 32'h0 || output_instru !== 32'h0050_0513) begin n_err++; $display("FAIL jstall_retain: got pc=%08h ins=%08h expected pc=00000000 ins=00500513", output_pc, output_instru); end
    endtask

    task automatic test_freeze();
        int t;
        do_reset();
        tick(); tick();
        rdy_in = 1'b0; jump_en = 1'b1; jump_target = 32'h0000_3000;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++; if ({output_valid, mem_rd_en, mem_a} !== {1'b0, 1'b1, 32'h1}) begin n_err++; $display("FAIL freeze_hold %0d: got v=%0b rd=%0b a=%08h expected v=0 rd=1 a=00000001", k, output_valid, mem_rd_en, mem_a); end
        end
        rdy_in = 1'b1; jump_en = 1'b0;
        wait_valid(20, t);
        n_cmp++; if (t !== 4) begin n_err++; $display("FAIL freeze_latency: got %0d expected 4", t); end
        n_cmp++; if (output_pc !== 32'h0 || output_instru !== 32'h0050_0513) begin n_err++; $display("FAIL freeze_word: got pc=%08h ins=%08h expected pc=00000000 ins=00500513", output_pc, output_instru); end
        tick();
        n_cmp++; if (mem_a !== 32'h4) begin n_err++; $display("FAIL freeze_next_addr: got %08h expected 00000004", mem_a); end
    endtask

    task automatic test_wrap();
        int t;
        do_reset();
        jump_en = 1'b1; jump_target = 32'hFFFF_FFFE;
        tick();
        jump_en = 1'b0;
        n_cmp++; if (mem_a !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: got %08h expected fffffffc", mem_a); end
        wait_valid(20, t);
        n_cmp++; if (t !== 5) begin n_err++; $display("FAIL wrap_latency: got %0d expected 5", t); end
        n_cmp++; if (output_pc !== 32'hFFFF_FFFC || output_instru !== ref_word(32'hFFFF_FFFC)) begin n_err++; $display("FAIL wrap_word: got pc=%08h ins=%08h expected pc=fffffffc ins=%08h", output_pc, output_instru, ref_word(32'hFFFF_FFFC)); end
        tick();
        n_cmp++; if ({mem_rd_en, mem_a} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL wrap_next: got rd=%0b a=%08h expected rd=1 a=00000000", mem_rd_en, mem_a); end
    endtask

    task automatic test_reset_midfetch();
        int t;
        do_reset();
        tick(); tick(); tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        n_cmp++; if ({output_valid, mem_rd_en, mem_a} !== {1'b0, 1'b0, 32'h0}) begin n_err++; $display("FAIL midrst_state: got v=%0b rd=%0b a=%08h expected v=0 rd=0 a=00000000", output_valid, mem_rd_en, mem_a); end
        wait_valid(20, t);
        n_cmp++; if (t !== 6) begin n_err++; $display("FAIL midrst_latency: got %0d expected 6", t); end
        n_cmp++; if (output_pc !== 32'h0) begin n_err++; $display("FAIL midrst_pc: got %08h expected 00000000", output_pc); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, hold_pc, hold_ins, tgt, off;
        logic        prev_v, rdy, jmp;
        int          seen;
        do_reset();
        exp_pc = 32'h0; prev_v = 1'b0; seen = 0; hold_pc = 32'h0; hold_ins = 32'h0;
        for (int i = 0; i < 800; i++) begin
            rdy = ($urandom_range(0, 9) != 0);
            jmp = ($urandom_range(0, 24) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & 32'h0000_FFFF);
            rdy_in = rdy; jump_en = jmp; jump_target = tgt;
            stall_in = ($urandom_range(0, 2) == 0);
            tick();
            if (rdy && jmp) exp_pc = tgt & ~32'h3;
            if (output_valid && !prev_v) begin
                n_cmp++;
                if (output_pc !== exp_pc || output_instru !== ref_word(exp_pc)) begin
                    n_err++;
                    $display("FAIL rand_word @%0d: got pc=%08h ins=%08h expected pc=%08h ins=%08h", i, output_pc, output_instru, exp_pc, ref_word(exp_pc));
                end
                hold_pc = output_pc; hold_ins = output_instru;
                exp_pc = exp_pc + 32'd4;
                seen++;
            end else if (output_valid && prev_v) begin
                n_cmp++;
                if (output_pc !== hold_pc || output_instru !== hold_ins) begin
                    n_err++;
                    $display("FAIL rand_hold @%0d: got pc=%08h ins=%08h expected pc=%08h ins=%08h", i, output_pc, output_instru, hold_pc, hold_ins);
                end
            end
            if (mem_rd_en) begin
                off = mem_a - exp_pc;
                n_cmp++;
                if (off >= 32'd4) begin n_err++; $display("FAIL rand_addr @%0d: got a=%08h expected within 4 of %08h", i, mem_a, exp_pc); end
            end
            prev_v = output_valid;
        end
        rdy_in = 1'b1; jump_en = 1'b0; stall_in = 1'b0;
        n_cmp++; if (seen < 20) begin n_err++; $display("FAIL rand_count: got %0d instructions expected at least 20", seen); end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; stall_in = 1'b0; jump_en = 1'b0;
        jump_target = 32'h0; mem_din = 8'h00;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h50; mem[3] = 8'h00;

        test_reset();
        test_basic();
        test_stall();
        test_jump();
        test_jump_stall();
        test_freeze();
        test_wrap();
        test_reset_midfetch();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
